// File: rtl/four_bit_rca.sv
// Registered 4-bit ripple-carry adder with carry, signed-overflow and zero flags.
// Optional macro FOUR_BIT_RCA_SUB_EN adds a Sub input that inverts B.
module four_bit_rca (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
`ifdef FOUR_BIT_RCA_SUB_EN
    input  logic       Sub,
`endif
    output logic [3:0] Sum,
    output logic       Cout,
    output logic       Ovf,
    output logic       Zero,
    output logic       out_valid
);

    logic [3:0] bmod_p0;
    logic [3:0] sum_p0;
    logic [4:0] carry_p0;

    // Stage p0: combinational ripple chain of four full-adder cells
    always_comb begin
`ifdef FOUR_BIT_RCA_SUB_EN
        bmod_p0 = Sub ? ~B : B;
`else
        bmod_p0 = B;
`endif
        carry_p0    = '0;
        sum_p0      = '0;
        carry_p0[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            sum_p0[i]     = A[i] ^ bmod_p0[i] ^ carry_p0[i];
            carry_p0[i+1] = (A[i] & bmod_p0[i]) | (A[i] & carry_p0[i]) | (bmod_p0[i] & carry_p0[i]);
        end
    end

    // Stage p1: result registers; data holds when no valid operands arrive
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum       <= 4'h0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
            Zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum  <= sum_p0;
                Cout <= carry_p0[4];
                Ovf  <= carry_p0[3] ^ carry_p0[4];
                Zero <= (sum_p0 == 4'h0);
            end
        end
    end

endmodule

// File: tb/tb_four_bit_rca.sv
// Self-checking bench for four_bit_rca: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_four_bit_rca;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       sub;
    logic [3:0] Sum;
    logic       Cout;
    logic       Ovf;
    logic       Zero;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    logic [3:0] m_sum;
    logic       m_cout;
    logic       m_ovf;
    logic       m_zero;
    logic       m_vld;

    always #5 clk = ~clk;

    four_bit_rca dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef FOUR_BIT_RCA_SUB_EN
        .Sub       (sub),
`endif
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .Zero      (Zero),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for carry, signed for overflow
    task automatic compute(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sb,
                           output logic [3:0] s, output logic co, output logic ov, output logic z);
        int bp, u, sa, sbv, ss;
        bp  = sb ? (15 - int'(b)) : int'(b);
        u   = int'(a) + bp + int'(ci);
        s   = 4'(u % 16);
        co  = (u >= 16);
        sa  = (a >= 8) ? int'(a) - 16 : int'(a);
        sbv = (bp >= 8) ? bp - 16 : bp;
        ss  = sa + sbv + int'(ci);
        ov  = (ss > 7) || (ss < -8);
        z   = (s == 4'h0);
    endtask

    task automatic tick();
        logic [3:0] s;
        logic co, ov, z;
        if (rst) begin
            m_sum = 4'h0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b1; m_vld = 1'b0;
        end else begin
            m_vld = in_valid;
            if (in_valid) begin
                compute(A, B, Cin, sub, s, co, ov, z);
                m_sum = s; m_cout = co; m_ovf = ov; m_zero = z;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".sum"},  8'(Sum),       8'(m_sum));
        check({tag, ".cout"}, 8'(Cout),      8'(m_cout));
        check({tag, ".ovf"},  8'(Ovf),       8'(m_ovf));
        check({tag, ".zero"}, 8'(Zero),      8'(m_zero));
        check({tag, ".vld"},  8'(out_valid), 8'(m_vld));
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ci, input logic sb);
        in_valid = v; A = a; B = b; Cin = ci; sub = sb;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        m_sum = 4'h0; m_cout = 1'b0; m_ovf = 1'b0; m_zero = 1'b1; m_vld = 1'b0;

        // Reset state
        tick();
        check("reset.sum", 8'(Sum), 8'h0);
        check("reset.zero", 8'(Zero), 8'h1);
        check_model("reset");

        // Sweep: Cin=1, B=F gives Sum=A, Cout=1
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 4'(a), 4'hF, 1'b1, 1'b0);
            tick();
            check("sweep.sum", 8'(Sum), 8'(a));
            check("sweep.cout", 8'(Cout), 8'h1);
            check("sweep.vld", 8'(out_valid), 8'h1);
            check_model("sweep");
        end

        // Positive overflow
        drive(1'b1, 4'h7, 4'h1, 1'b0, 1'b0);
        tick();
        check("ovf7p1.sum", 8'(Sum), 8'h8);
        check("ovf7p1.cout", 8'(Cout), 8'h0);
        check("ovf7p1.ovf", 8'(Ovf), 8'h1);
        check("ovf7p1.zero", 8'(Zero), 8'h0);

        // All ones with carry in, then negative overflow to zero
        drive(1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
        tick();
        check("ff1.sum", 8'(Sum), 8'hF);
        check("ff1.cout", 8'(Cout), 8'h1);
        check("ff1.ovf", 8'(Ovf), 8'h0);
        drive(1'b1, 4'h8, 4'h8, 1'b0, 1'b0);
        tick();
        check("88.sum", 8'(Sum), 8'h0);
        check("88.cout", 8'(Cout), 8'h1);
        check("88.ovf", 8'(Ovf), 8'h1);
        check("88.zero", 8'(Zero), 8'h1);

        // Hold: one valid, then three idle cycles
        drive(1'b1, 4'h2, 4'h3, 1'b0, 1'b0);
        tick();
        check("hold0.sum", 8'(Sum), 8'h5);
        check("hold0.vld", 8'(out_valid), 8'h1);
        drive(1'b0, 4'hA, 4'hA, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold.sum", 8'(Sum), 8'h5);
            check("hold.vld", 8'(out_valid), 8'h0);
            check_model("hold");
        end

        // rst without a clock edge changes nothing
        rst = 1'b1;
        #3;
        check("asyncrst.sum", 8'(Sum), 8'h5);
        check("asyncrst.zero", 8'(Zero), 8'h0);

        // Reset wins over valid operands on the same edge
        drive(1'b1, 4'h3, 4'h4, 1'b0, 1'b0);
        tick();
        check("rstprio.sum", 8'(Sum), 8'h0);
        check("rstprio.cout", 8'(Cout), 8'h0);
        check("rstprio.ovf", 8'(Ovf), 8'h0);
        check("rstprio.zero", 8'(Zero), 8'h1);
        check("rstprio.vld", 8'(out_valid), 8'h0);

        // First valid after reset appears one cycle later
        rst = 1'b0;
        drive(1'b1, 4'h3, 4'h4, 1'b0, 1'b0);
        tick();
        check("postrst.sum", 8'(Sum), 8'h7);
        check("postrst.vld", 8'(out_valid), 8'h1);

`ifdef FOUR_BIT_RCA_SUB_EN
        drive(1'b1, 4'h5, 4'h3, 1'b1, 1'b1);
        tick();
        check("sub53.sum", 8'(Sum), 8'h2);
        check("sub53.cout", 8'(Cout), 8'h1);
        check("sub53.ovf", 8'(Ovf), 8'h0);
        drive(1'b1, 4'h3, 4'h5, 1'b1, 1'b1);
        tick();
        check("sub35.sum", 8'(Sum), 8'hE);
        check("sub35.cout", 8'(Cout), 8'h0);
`endif

        // Randomized traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 19) == 0);
`ifdef FOUR_BIT_RCA_SUB_EN
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'b0);
`endif
            tick();
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
